// File: rtl/uart_rx_word36.sv
// 8N1 oversampling UART receiver that packs five bytes into a 36-bit word.
// Completed words are offered on a valid/ready port; a stale partial word times out.
module uart_rx_word36 #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [35:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun
);

    localparam int HALF     = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GW       = $clog2(GAP_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t state, state_n;

    logic          rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [2:0]    byte_idx;
    logic [31:0]   stage;
    logic [GW-1:0] gap_cnt;

    logic bit_tick, byte_good, byte_bad;
    logic gap_hit, word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        bit_tick  = 1'b0;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == CW'(HALF - 1))
                    state_n = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    bit_tick = 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    if (rxs) begin
                        byte_good = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        byte_bad = 1'b1;
                        state_n  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign gap_hit   = (state == IDLE) && (byte_idx != 3'd0)
                    && (gap_cnt == GW'(GAP_CLKS));
    assign word_done = byte_good && (byte_idx == 3'd4);

    // cnt free-runs outside framing states; it is zeroed on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            stage    <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state != state_n || bit_tick) cnt <= '0;
            else                              cnt <= cnt + CW'(1);

            if (state_n == DATA && state != DATA) bit_idx <= '0;
            else if (bit_tick)                    bit_idx <= bit_idx + 3'd1;

            if (bit_tick) shreg <= {rxs, shreg[7:1]};

            if (byte_bad) begin
                byte_idx <= '0;
            end else if (byte_good) begin
                if (byte_idx == 3'd4) begin
                    byte_idx <= '0;
                end else begin
                    stage[{byte_idx[1:0], 3'b000} +: 8] <= shreg;
                    byte_idx <= byte_idx + 3'd1;
                end
            end else if (gap_hit) begin
                byte_idx <= '0;
            end

            if (state != IDLE || byte_idx == 3'd0 || gap_hit) gap_cnt <= '0;
            else                                            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= byte_bad;
            overrun   <= 1'b0;
            if (word_done) begin
                if (!word_valid || word_ready) begin
                    word_data  <= {shreg[3:0], stage};
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word36.sv
// Directed bench for uart_rx_word36 at 16 clocks/bit with a 4-bit gap timeout.
// Pulse and handshake monitors feed counters checked after each scenario.
module tb_uart_rx_word36;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [35:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int          hs_cnt = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    logic [35:0] last_word = '0;

    int hs0, fe0, ov0;

    uart_rx_word36 #(.CLKS_PER_BIT(16), .GAP_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) begin
                hs_cnt    = hs_cnt + 1;
                last_word = word_data;
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (overrun)   ov_cnt = ov_cnt + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [35:0] obs,
                         input logic [35:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(16);
        end
        rx = stop;
        cyc(16);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [39:0] w);
        for (int k = 0; k < 5; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic mark();
        hs0 = hs_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
    endtask

    initial begin
        rst        = 1'b1;
        rx         = 1'b1;
        word_ready = 1'b0;
        cyc(5);
        check("rst_valid", 36'(word_valid), 36'd0);
        check("rst_data", word_data, 36'd0);
        check("rst_ferr", 36'(frame_err), 36'd0);
        check("rst_ovr", 36'(overrun), 36'd0);
        rst = 1'b0;
        cyc(10);

        // 1: single word, consumer always ready
        word_ready = 1'b1;
        mark();
        send_word(40'hF9_12_34_56_78);
        cyc(20);
        check("t1_hs", 36'(hs_cnt - hs0), 36'd1);
        check("t1_data", last_word, 36'h9_1234_5678);
        check("t1_ferr", 36'(fe_cnt - fe0), 36'd0);
        check("t1_ovr", 36'(ov_cnt - ov0), 36'd0);
        check("t1_valid", 36'(word_valid), 36'd0);

        // 2: stalled consumer, second word overruns
        word_ready = 1'b0;
        mark();
        send_word(40'hA5_44_33_22_11);
        cyc(5);
        check("t2_validA", 36'(word_valid), 36'd1);
        check("t2_dataA", word_data, 36'h5_4433_2211);
        check("t2_ovrA", 36'(ov_cnt - ov0), 36'd0);
        send_word(40'hF6_04_03_02_01);
        cyc(5);
        check("t2_ovr", 36'(ov_cnt - ov0), 36'd1);
        check("t2_hold", word_data, 36'h5_4433_2211);
        check("t2_hs0", 36'(hs_cnt - hs0), 36'd0);
        word_ready = 1'b1;
        cyc(3);
        check("t2_hs", 36'(hs_cnt - hs0), 36'd1);
        check("t2_got", last_word, 36'h5_4433_2211);
        check("t2_clr", 36'(word_valid), 36'd0);
        cyc(20);
        check("t2_noB", 36'(hs_cnt - hs0), 36'd1);

        // 3: framing error, break, then a fresh word
        mark();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        rx = 1'b0;
        cyc(20);
        check("t3_wait", 36'(3'(dut.state)), 36'd4);
        cyc(20);
        check("t3_still", 36'(3'(dut.state)), 36'd4);
        check("t3_ferr", 36'(fe_cnt - fe0), 36'd1);
        rx = 1'b1;
        cyc(20);
        check("t3_idle", 36'(3'(dut.state)), 36'd0);
        send_word(40'h08_67_45_23_01);
        cyc(20);
        check("t3_hs", 36'(hs_cnt - hs0), 36'd1);
        check("t3_data", last_word, 36'h8_6745_2301);
        check("t3_ferr1", 36'(fe_cnt - fe0), 36'd1);

        // 4: short glitch rejected in START
        mark();
        rx = 1'b0;
        cyc(4);
        check("t4_start", 36'(3'(dut.state)), 36'd1);
        cyc(2);
        rx = 1'b1;
        cyc(20);
        check("t4_idle", 36'(3'(dut.state)), 36'd0);
        check("t4_valid", 36'(word_valid), 36'd0);
        check("t4_ferr", 36'(fe_cnt - fe0), 36'd0);
        check("t4_hs", 36'(hs_cnt - hs0), 36'd0);

        // 5: partial word times out
        mark();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        cyc(100);
        check("t5_hs0", 36'(hs_cnt - hs0), 36'd0);
        send_word(40'h98_76_54_32_10);
        cyc(20);
        check("t5_hs", 36'(hs_cnt - hs0), 36'd1);
        check("t5_data", last_word, 36'h8_7654_3210);
        check("t5_ovr", 36'(ov_cnt - ov0), 36'd0);

        // 6: reset in the middle of the third byte
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        rx = 1'b0;
        cyc(16);
        rx = 1'b1;
        cyc(40);
        rst = 1'b1;
        cyc(3);
        check("t6_rvalid", 36'(word_valid), 36'd0);
        check("t6_rdata", word_data, 36'd0);
        rx = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(30);
        check("t6_valid", 36'(word_valid), 36'd0);
        mark();
        send_word(40'h07_89_AB_CD_EF);
        cyc(20);
        check("t6_hs", 36'(hs_cnt - hs0), 36'd1);
        check("t6_data", last_word, 36'h7_89AB_CDEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
